// File: rtl/counter_arbiter.sv
// Round-robin arbiter that lends one shared W-bit up-counter to NREQ requesters,
// each for its own latched duration, followed by a one-cycle done pulse.
module counter_arbiter #(
    parameter int NREQ = 4,
    parameter int W    = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*W-1:0] dur,
    output logic [NREQ-1:0]   grant,
    output logic [W-1:0]      count,
    output logic              busy,
    output logic [NREQ-1:0]   done
);
    localparam int LW = $clog2(NREQ);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state_q, state_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [NREQ-1:0] done_q, done_d;
    logic [W-1:0]    count_q, count_d;
    logic [W-1:0]    dlat_q, dlat_d;
    logic [LW-1:0]   last_q, last_d;

    logic [W-1:0]    dur_arr [NREQ];
    logic [LW-1:0]   win_idx;
    logic            win_found;
    logic [LW:0]     cand_sum;
    logic [LW-1:0]   cand;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_dur
            assign dur_arr[gi] = dur[gi*W +: W];
        end
    endgenerate

    // Scan upward from the requester after the last owner, wrapping at NREQ.
    always_comb begin
        win_idx   = '0;
        win_found = 1'b0;
        cand_sum  = '0;
        cand      = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand_sum = {1'b0, last_q} + (LW+1)'(k);
            if (cand_sum >= (LW+1)'(NREQ))
                cand_sum = cand_sum - (LW+1)'(NREQ);
            cand = cand_sum[LW-1:0];
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        done_d  = '0;
        count_d = count_q;
        dlat_d  = dlat_q;
        last_d  = last_q;
        unique case (state_q)
            IDLE: begin
                count_d = '0;
                grant_d = '0;
                if (win_found) begin
                    grant_d = NREQ'(1) << win_idx;
                    dlat_d  = dur_arr[win_idx];
                    last_d  = win_idx;
                    state_d = RUN;
                end
            end
            RUN: begin
                // Abort wins over terminal; pointer stays on the aborted owner.
                if (!req[last_q]) begin
                    state_d = IDLE;
                    grant_d = '0;
                    count_d = '0;
                end else if (count_q == dlat_q - W'(1)) begin
                    state_d = DONE;
                    grant_d = '0;
                    done_d  = NREQ'(1) << last_q;
                end else begin
                    count_d = count_q + W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
                grant_d = '0;
                count_d = '0;
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                count_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            done_q  <= '0;
            count_q <= '0;
            dlat_q  <= '0;
            last_q  <= LW'(NREQ-1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            count_q <= count_d;
            dlat_q  <= dlat_d;
            last_q  <= last_d;
        end
    end

    assign grant = grant_q;
    assign done  = done_q;
    assign count = count_q;
    assign busy  = (state_q == RUN);
endmodule

// File: tb/tb_counter_arbiter.sv
// Self-checking bench for counter_arbiter: directed vector table, corner-case
// sequences, and randomized traffic against an interval-level reference model.
module tb_counter_arbiter;
    localparam int NREQ = 4;
    localparam int W    = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [15:0] dur;
    logic [3:0]  grant;
    logic [3:0]  count;
    logic        busy;
    logic [3:0]  done;

    int total = 0;
    int bad   = 0;

    // Reference model: phase 0=idle 1=owning 2=done-cycle; elapsed cycles of interval.
    int m_phase, m_owner, m_elapsed, m_len, m_last, m_done;

    counter_arbiter #(.NREQ(NREQ), .W(W)) dut (
        .clk(clk), .reset(reset), .req(req), .dur(dur),
        .grant(grant), .count(count), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [3:0]  rq;
        logic [15:0] du;
        logic [3:0]  g;
        logic [3:0]  c;
        logic        b;
        logic [3:0]  d;
    } vec_t;

    vec_t tbl [12];

    function automatic logic [3:0] oh(int i);
        return (i < 0) ? 4'b0000 : 4'(1 << i);
    endfunction

    task automatic model_step();
        logic [15:0] sh;
        if (!reset) begin
            m_phase = 0; m_owner = -1; m_elapsed = 0; m_last = NREQ-1; m_done = -1;
        end else begin
            case (m_phase)
                0: begin
                    m_done = -1;
                    m_elapsed = 0;
                    for (int k = 1; k <= NREQ; k++) begin
                        int c;
                        c = (m_last + k) % NREQ;
                        if (m_owner < 0 && req[c]) m_owner = c;
                    end
                    if (m_owner >= 0) begin
                        sh = dur >> (m_owner * W);
                        m_len = (sh[3:0] == 4'd0) ? 16 : int'(sh[3:0]);
                        m_last = m_owner;
                        m_phase = 1;
                    end
                end
                1: begin
                    if (!req[m_owner]) begin
                        m_phase = 0; m_owner = -1; m_elapsed = 0;
                    end else if (m_elapsed + 1 == m_len) begin
                        m_phase = 2; m_done = m_owner; m_owner = -1;
                    end else begin
                        m_elapsed++;
                    end
                end
                default: begin
                    m_done = -1; m_elapsed = 0; m_phase = 0;
                end
            endcase
        end
    endtask

    task automatic tick(input logic r, input logic [3:0] q, input logic [15:0] d);
        reset = r;
        req   = q;
        dur   = d;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (grant=%b count=%0d busy=%b done=%b)",
                     name, act, exp, grant, count, busy, done);
        end
    endtask

    task automatic cmp_model(input string name);
        check(name, 32'({grant, count, busy, done}),
              32'({oh(m_owner), 4'(m_elapsed % 16), 1'(m_owner >= 0), oh(m_done)}));
    endtask

    logic [3:0] seen [$];
    logic [3:0] prev_g;
    logic [3:0] rr_exp [5];
    logic [3:0] rq;
    logic [3:0] done_cnt;
    int gcyc, ndone;
    bit finished;

    initial begin
        // Inputs then expected registered outputs after the following edge.
        tbl[0]  = '{1'b1, 4'b0000, 16'h0000, 4'b0000, 4'd0, 1'b0, 4'b0000};
        tbl[1]  = '{1'b1, 4'b0000, 16'h0000, 4'b0000, 4'd0, 1'b0, 4'b0000};
        tbl[2]  = '{1'b1, 4'b0000, 16'h0000, 4'b0000, 4'd0, 1'b0, 4'b0000};
        tbl[3]  = '{1'b1, 4'b0000, 16'h0000, 4'b0000, 4'd0, 1'b0, 4'b0000};
        tbl[4]  = '{1'b1, 4'b0000, 16'h0000, 4'b0000, 4'd0, 1'b0, 4'b0000};
        tbl[5]  = '{1'b1, 4'b0010, 16'h0030, 4'b0010, 4'd0, 1'b1, 4'b0000};
        tbl[6]  = '{1'b1, 4'b0010, 16'h0030, 4'b0010, 4'd1, 1'b1, 4'b0000};
        tbl[7]  = '{1'b1, 4'b0010, 16'h0030, 4'b0010, 4'd2, 1'b1, 4'b0000};
        tbl[8]  = '{1'b1, 4'b0010, 16'h0030, 4'b0000, 4'd2, 1'b0, 4'b0010};
        tbl[9]  = '{1'b1, 4'b0000, 16'h0030, 4'b0000, 4'd0, 1'b0, 4'b0000};
        tbl[10] = '{1'b1, 4'b0100, 16'h0300, 4'b0100, 4'd0, 1'b1, 4'b0000};
        tbl[11] = '{1'b0, 4'b0100, 16'h0300, 4'b0000, 4'd0, 1'b0, 4'b0000};

        reset = 1'b0; req = '0; dur = '0;
        tick(1'b0, 4'b0000, 16'h0000);
        tick(1'b0, 4'b0000, 16'h0000);
        check("reset_state", 32'({grant, count, busy, done}), 32'h0);

        for (int i = 0; i < 12; i++) begin
            tick(tbl[i].rst, tbl[i].rq, tbl[i].du);
            check($sformatf("vec%0d", i), 32'({grant, count, busy, done}),
                  32'({tbl[i].g, tbl[i].c, tbl[i].b, tbl[i].d}));
        end

        // Round robin with all requesters and duration 2.
        tick(1'b0, 4'b0000, 16'h0000);
        prev_g = '0;
        for (int i = 0; i < 22; i++) begin
            tick(1'b1, 4'b1111, 16'h2222);
            cmp_model("rr_cycle");
            if (grant != 4'b0000 && prev_g == 4'b0000) seen.push_back(grant);
            prev_g = grant;
        end
        rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        for (int k = 0; k < 5; k++)
            check($sformatf("rr_order%0d", k), 32'((k < seen.size()) ? seen[k] : 4'b0000),
                  32'(rr_exp[k]));

        // Duration 0 means a full 16-cycle wrap.
        tick(1'b0, 4'b0000, 16'h0000);
        gcyc = 0; ndone = 0; finished = 0; done_cnt = '0;
        for (int i = 0; i < 40 && !finished; i++) begin
            tick(1'b1, 4'b0100, 16'h0000);
            cmp_model("wrap_cycle");
            if (grant == 4'b0100) gcyc++;
            if (done == 4'b0100) begin
                ndone++;
                done_cnt = count;
                finished = 1;
            end
        end
        check("wrap_len", 32'(gcyc), 32'd16);
        check("wrap_done", 32'(ndone), 32'd1);
        check("wrap_last_count", 32'(done_cnt), 32'd15);

        // Abort at count 2, then requester 3 beats requester 0.
        tick(1'b0, 4'b0000, 16'h0000);
        for (int i = 0; i < 3; i++) tick(1'b1, 4'b0001, 16'h0005);
        check("abort_pre", 32'({grant, count}), 32'({4'b0001, 4'd2}));
        tick(1'b1, 4'b0000, 16'h0005);
        check("abort", 32'({grant, count, busy, done}), 32'h0);
        tick(1'b1, 4'b1001, 16'h0005);
        check("abort_rr", 32'(grant), 32'(4'b1000));
        cmp_model("abort_model");

        // Reset in the middle of an interval.
        tick(1'b0, 4'b0000, 16'h0000);
        for (int i = 0; i < 5; i++) tick(1'b1, 4'b0010, 16'h0080);
        check("rst_mid_pre", 32'({grant, count}), 32'({4'b0010, 4'd4}));
        tick(1'b0, 4'b0010, 16'h0080);
        check("rst_mid", 32'({grant, count, busy, done}), 32'h0);
        tick(1'b1, 4'b0011, 16'h0080);
        check("rst_rr", 32'(grant), 32'(4'b0001));
        tick(1'b1, 4'b0011, 16'h0080);
        check("rst_no_done", 32'(done), 32'h0);

        // Randomized traffic against the model.
        tick(1'b0, 4'b0000, 16'h0000);
        rq = '0;
        for (int i = 0; i < 3000; i++) begin
            for (int b = 0; b < 4; b++)
                if ($urandom_range(0, 7) == 0) rq[b] = ~rq[b];
            tick(($urandom_range(0, 199) != 0), rq, 16'($urandom));
            cmp_model("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
